// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared op codes, state encoding and defaults for the FPU issuer
package fpu_pkg;

  localparam int DEFAULT_TIMEOUT = 64;

  // FPU op select codes (5-bit encoding shared with the FPU top)
  localparam logic [4:0] FADD  = 5'd0;
  localparam logic [4:0] FSUB  = 5'd1;
  localparam logic [4:0] FMUL  = 5'd2;
  localparam logic [4:0] FDIV  = 5'd3;
  localparam logic [4:0] FSQRT = 5'd4;
  localparam logic [4:0] FMIN  = 5'd5;
  localparam logic [4:0] FMAX  = 5'd6;
  localparam logic [4:0] FEQ   = 5'd8;
  localparam logic [4:0] FLT   = 5'd9;
  localparam logic [4:0] FLE   = 5'd10;

  // Issuer state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT
  } state_e;

endpackage

// File: rtl/fpu_issue.sv
// rtl/fpu_issue.sv - single-outstanding FPU en/ready initiator with timeout guard
module fpu_issue
  import fpu_pkg::*;
#(
  parameter int TAG_W   = 6,
  parameter int OP_W    = 5,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OP_W-1:0]  req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             fpu_en,
  output logic [OP_W-1:0]  fpu_op,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  input  logic [31:0]      fpu_c,
  input  logic             fpu_ready,
  output logic             wb_valid,
  output logic [31:0]      wb_data,
  output logic [TAG_W-1:0] wb_tag,
  output logic             err_timeout
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               req_ready_q, req_ready_d;
  logic               fpu_en_q, fpu_en_d;
  logic               wb_valid_q, wb_valid_d;
  logic [31:0]        wb_data_q, wb_data_d;
  logic [TAG_W-1:0]   wb_tag_q, wb_tag_d;
  logic               err_q, err_d;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // Next-state, counter and registered-output computation
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    tag_d      = tag_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    wb_tag_d   = wb_tag_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          tag_d   = req_tag;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // units register their inputs, so a ready here cannot belong to this op
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (fpu_ready) begin
          wb_valid_d = 1'b1;
          wb_data_d  = fpu_c;
          wb_tag_d   = tag_q;
          state_d    = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          wb_valid_d = 1'b1;
          wb_data_d  = '0;
          wb_tag_d   = tag_q;
          err_d      = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_ready_d = (state_d == S_IDLE);
    fpu_en_d    = (state_d == S_ISSUE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      req_ready_q <= 1'b1;
      fpu_en_q    <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_tag_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tag_q       <= tag_d;
      req_ready_q <= req_ready_d;
      fpu_en_q    <= fpu_en_d;
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_tag_q    <= wb_tag_d;
      err_q       <= err_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign fpu_en      = fpu_en_q;
  assign fpu_op      = op_q;
  assign fpu_a       = a_q;
  assign fpu_b       = b_q;
  assign wb_valid    = wb_valid_q;
  assign wb_data     = wb_data_q;
  assign wb_tag      = wb_tag_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_fpu_issue.sv
// tb/tb_fpu_issue.sv - scoreboard bench for fpu_issue with a behavioural FPU unit
module tb_fpu_issue;
  import fpu_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_a, req_b;
  logic [5:0]  req_tag;
  logic        fpu_en;
  logic [4:0]  fpu_op;
  logic [31:0] fpu_a, fpu_b, fpu_c;
  logic        fpu_ready;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [5:0]  wb_tag;
  logic        err_timeout;

  fpu_issue #(.TAG_W(6), .OP_W(5), .TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .fpu_en(fpu_en), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_c(fpu_c), .fpu_ready(fpu_ready),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_tag(wb_tag),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d;
    logic [5:0]  tag;
    logic        err;
    int          at;
  } exp_t;
  exp_t sb[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural unit: answers unit_lat cycles after en (0 = never), plus injected spurious readies
  int unit_lat = 1;
  int spur_a = -1;
  int spur_b = -1;

  function automatic logic [31:0] unit_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == FEQ) return {31'b0, a == b};
    if (op == FADD) return (a == 32'h40000000 && b == 32'h3F800000) ? 32'h40400000 : 32'hFFFFFFFF;
    return 32'h0;
  endfunction

  initial begin
    logic        en_s;
    logic [4:0]  op_s;
    logic [31:0] a_s, b_s, res;
    int          pend;
    pend = 0;
    res = '0;
    fpu_ready = 1'b0;
    fpu_c = '0;
    forever begin
      @(posedge clk);
      en_s = fpu_en; op_s = fpu_op; a_s = fpu_a; b_s = fpu_b;
      #1;
      fpu_ready = 1'b0;
      if (en_s) begin
        pend = unit_lat;
        res  = unit_fn(op_s, a_s, b_s);
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          fpu_ready = 1'b1;
          fpu_c = res;
        end
      end
      if (cyc == spur_a || cyc == spur_b) begin
        fpu_ready = 1'b1;
        fpu_c = 32'hBAD0BAD0;
      end
    end
  end

  // Monitor: every wb_valid must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (wb_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_wb_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("wb_data", wb_data, e.d);
          chk("wb_tag", {26'b0, wb_tag}, {26'b0, e.tag});
          chk("wb_cycle", cyc, e.at);
          chk("wb_err_timeout", {31'b0, err_timeout}, {31'b0, e.err});
        end
      end
    end
  end

  // Present a request, wait (bounded) for acceptance, queue the expected writeback
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] tag, input logic [31:0] exp_d, input logic exp_err,
                       input int wb_delay, output int t);
    exp_t e;
    bit ok;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    ok = 1'b0;
    t = -1;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      if (req_ready) begin
        ok = 1'b1;
        t = cyc;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    else begin
      e.d = exp_d; e.tag = tag; e.err = exp_err; e.at = t + wb_delay;
      sb.push_back(e);
    end
    #1;
    req_valid = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 40 && sb.size() != 0; n++) step(1);
    chk("scoreboard_drained", sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2;
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
    step(3);
    rst = 1'b0;
    step(1);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_fpu_en", {31'b0, fpu_en}, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_err", {31'b0, err_timeout}, 32'd0);

    // 1-cycle FEQ unit, equal operands
    unit_lat = 1;
    issue(FEQ, 32'h3F800000, 32'h3F800000, 6'd5, 32'h00000001, 1'b0, 3, t);
    chk("t1_en_at_t1", {31'b0, fpu_en}, 32'd1);
    step(1);
    chk("t1_en_low_t2", {31'b0, fpu_en}, 32'd0);
    drain();

    // 5-cycle FADD unit: 2.0 + 1.0 = 3.0
    unit_lat = 5;
    issue(FADD, 32'h40000000, 32'h3F800000, 6'd7, 32'h40400000, 1'b0, 7, t);
    for (int k = 1; k <= 6; k++) begin
      chk("t2_req_ready_low", {31'b0, req_ready}, 32'd0);
      chk("t2_fpu_a_stable", fpu_a, 32'h40000000);
      chk("t2_fpu_b_stable", fpu_b, 32'h3F800000);
      step(1);
    end
    chk("t2_req_ready_back", {31'b0, req_ready}, 32'd1);
    drain();

    // Unit never answers: timeout, then a normal op with sticky error
    unit_lat = 0;
    issue(FADD, 32'h11111111, 32'h22222222, 6'd12, 32'h00000000, 1'b1, 2 + TO, t);
    drain();
    unit_lat = 1;
    issue(FEQ, 32'h40400000, 32'h40400000, 6'd9, 32'h00000001, 1'b1, 3, t);
    drain();
    chk("t3_err_sticky", {31'b0, err_timeout}, 32'd1);

    // Back-to-back with held req_valid
    issue(FEQ, 32'h3F800000, 32'h40000000, 6'd1, 32'h00000000, 1'b1, 3, t);
    issue(FEQ, 32'h40000000, 32'h40000000, 6'd2, 32'h00000001, 1'b1, 3, t2);
    chk("t4_second_accept", t2, t + 3);
    drain();

    // Spurious ready in IDLE, then in the ISSUE cycle
    unit_lat = 2;
    spur_a = cyc + 1;
    step(3);
    chk("t5_idle_req_ready", {31'b0, req_ready}, 32'd1);
    spur_b = cyc + 1;
    issue(FADD, 32'h40000000, 32'h3F800000, 6'd33, 32'h40400000, 1'b1, 4, t);
    drain();

    // Reset in the 2nd WAIT cycle, late ready afterwards
    unit_lat = 4;
    issue(FEQ, 32'h55555555, 32'h55555555, 6'd44, 32'h00000001, 1'b1, 6, t);
    void'(sb.pop_back());
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t6_req_ready", {31'b0, req_ready}, 32'd1);
    chk("t6_fpu_en", {31'b0, fpu_en}, 32'd0);
    chk("t6_fpu_op", {27'b0, fpu_op}, 32'd0);
    chk("t6_fpu_a", fpu_a, 32'd0);
    chk("t6_fpu_b", fpu_b, 32'd0);
    chk("t6_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("t6_wb_data", wb_data, 32'd0);
    chk("t6_wb_tag", {26'b0, wb_tag}, 32'd0);
    chk("t6_err", {31'b0, err_timeout}, 32'd0);
    step(5);
    chk("t6_late_ready_ignored", {31'b0, req_ready}, 32'd1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_issue.md
Name: fpu_issue

Overview:
- Initiator side of the FPU en/ready protocol: accepts one FP op from the core pipeline, drives operands and a single-cycle en pulse to the FPU units, then waits for ready.
- Captures the unit's registered 32-bit result and presents it to writeback with the request's tag.
- Sits between decode/execute and the FPU units (compare, add, mul, …). Provides back-pressure and a timeout guard against a unit that never answers.

Parameters:
- TAG_W, 6, width of destination-register tag carried through.
- OP_W, 5, width of FPU op select.
- TIMEOUT, 64, max WAIT cycles before abort (must be >=2).
- CNT_W, 7, width of timeout counter (must satisfy 2^CNT_W > TIMEOUT).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents an op.
- req_ready  out  1  issuer can accept (high only in IDLE).
- req_op  in  OP_W  op select.
- req_a  in  32  operand a.
- req_b  in  32  operand b.
- req_tag  in  TAG_W  destination tag.
- fpu_en  out  1  one-cycle start pulse to FPU units.
- fpu_op  out  OP_W  latched op, stable ISSUE..WAIT.
- fpu_a  out  32  latched operand a.
- fpu_b  out  32  latched operand b.
- fpu_c  in  32  unit result, valid when fpu_ready=1.
- fpu_ready  in  1  unit completion, one-cycle pulse.
- wb_valid  out  1  one-cycle result strobe.
- wb_data  out  32  result.
- wb_tag  out  TAG_W  tag of completed op.
- err_timeout  out  1  sticky: a unit failed to answer.

Behaviour:
- Reset: all outputs are registered. On rst: state=IDLE, fpu_en=0, wb_valid=0, wb_data=0, wb_tag=0, fpu_op/a/b=0, err_timeout=0, counter=0. rst mid-operation aborts with no wb_valid; a late fpu_ready after reset is ignored.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op/a/b/tag and go to ISSUE.
  - fpu_ready in IDLE is ignored.
- ISSUE (exactly 1 cycle):
  - fpu_en=1; clear counter; go to WAIT.
  - fpu_ready in this cycle is ignored, because units register and the earliest legal ready is the next cycle.
- WAIT:
  - fpu_en=0; counter increments each cycle.
  - On fpu_ready: next cycle wb_valid=1, wb_data=fpu_c, wb_tag=latched tag; state goes to IDLE.
  - Else if counter==TIMEOUT-1: next cycle wb_valid=1, wb_data=0, err_timeout=1 (sticky until rst); state goes to IDLE.
  - If fpu_ready arrives in the same cycle as the timeout, fpu_ready wins and no error is raised.
- Latency for a 1-cycle unit:
  - accept at cycle t, en at t+1, ready at t+2, wb_valid at t+3.
  - A unit with latency L gives wb_valid at t+2+L.
- Back-to-back: req_ready=1 in the wb_valid cycle (state IDLE), so a new accept can coincide with the previous writeback.
- wb_valid is exactly one cycle; wb_data/wb_tag hold until the next wb_valid.
- fpu_op/a/b hold their latched values until the next acceptance.
- Only one op is ever outstanding.

Decomposition:
- Shared package fpu_pkg:
  - op-code localparams (FEQ, FLT, FLE, FADD, FSUB, FMUL, …);
  - state encoding localparams;
  - default TIMEOUT.
- No sub-module: FSM, counter and result register stay in one module. Unit muxing of fpu_c/fpu_ready is the FPU top's job.

Test Plan:
- 1-cycle unit model computing FEQ; req a=0x3F800000, b=0x3F800000, tag=5 accepted at t -> fpu_en high only at t+1; wb_valid at t+3 with wb_data=0x00000001, wb_tag=5.
- Unit latency 5; a=0x40000000, b=0x3F800000, FADD -> wb_valid at t+7 with wb_data=0x40400000. req_ready low t+1..t+6; fpu_a/fpu_b stable throughout.
- TIMEOUT=8, unit never answers -> wb_valid with wb_data=0 and err_timeout=1 on the 8th cycle after WAIT entry. Then a normal op completes correctly while err_timeout stays 1.
- Back-to-back: req_valid held high with two ops tags 1,2 on a 1-cycle unit -> second accept in the same cycle as first wb_valid; wb_valid at t+3 and t+6.
- Spurious fpu_ready in IDLE and in the ISSUE cycle -> no wb_valid, no state change; the real ready completes normally.
- rst asserted in the 2nd WAIT cycle -> next cycle all outputs are 0 and req_ready=1. A late fpu_ready produces no wb_valid.
